// File: rtl/montgomery_shift_sched_if.sv
// Request, configuration, datapath and result signals of the montgomery_shift scheduler.
// The scheduler uses the slave view; the client and datapath side use the master view.
interface montgomery_shift_sched_if #(
  parameter int LOGQ  = 32,
  parameter int LOGL1 = 5,
  parameter int LOGL2 = 5,
  parameter int LOGL3 = 5,
  parameter int NREQ  = 4,
  parameter int LOGT  = 33
);
  localparam int K   = 2 * LOGQ;
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*K-1:0] req_C;
  logic              cfg_we;
  logic [IDW-1:0]    cfg_id;
  logic [LOGL1-1:0]  cfg_L1;
  logic [LOGL2-1:0]  cfg_L2;
  logic [LOGL3-1:0]  cfg_L3;
  logic [K-1:0]      dp_C;
  logic [LOGL1-1:0]  dp_L1;
  logic [LOGL2-1:0]  dp_L2;
  logic [LOGL3-1:0]  dp_L3;
  logic [LOGT-1:0]   dp_T;
  logic              res_valid;
  logic              res_ready;
  logic [LOGT-1:0]   res_T;
  logic [IDW-1:0]    res_id;
  logic              busy;

  modport slave (
    input  req_valid, req_C, cfg_we, cfg_id, cfg_L1, cfg_L2, cfg_L3, dp_T, res_ready,
    output req_ready, dp_C, dp_L1, dp_L2, dp_L3, res_valid, res_T, res_id, busy
  );

  modport master (
    output req_valid, req_C, cfg_we, cfg_id, cfg_L1, cfg_L2, cfg_L3, dp_T, res_ready,
    input  req_ready, dp_C, dp_L1, dp_L2, dp_L3, res_valid, res_T, res_id, busy
  );
endinterface

// File: rtl/montgomery_shift_sched.sv
// Round-robin scheduler sharing one fixed-latency montgomery_shift pipeline between NREQ clients,
// with per-client shift configuration, a tag line matching the datapath and a credit-guarded result FIFO.
module montgomery_shift_sched #(
  parameter int LOGQ       = 32,
  parameter int LOGL1      = 5,
  parameter int LOGL2      = 5,
  parameter int LOGL3      = 5,
  parameter int USE_L3     = 1,
  parameter int NREQ       = 4,
  parameter int LAT        = 7,
  parameter int FIFO_DEPTH = 8,
  parameter int LOGT       = 33
) (
  input logic clk,
  input logic rst,
  montgomery_shift_sched_if.slave bus
);
  localparam int K   = 2 * LOGQ;
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = LOGT + IDW;

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]    credits_q, credits_d;
  logic [NREQ-1:0]  grant_s;
  logic [IDW-1:0]   gid_s;
  logic [K-1:0]     csel_s;
  logic             hs_s;
  logic             push_s;
  logic             pop_s;

  logic [LOGL1-1:0] cfg_l1_q [NREQ];
  logic [LOGL2-1:0] cfg_l2_q [NREQ];
  logic [LOGL3-1:0] cfg_l3_q [NREQ];

  logic [K-1:0]     dp_c_q, dp_c_d;
  logic [LOGL1-1:0] dp_l1_q, dp_l1_d;
  logic [LOGL2-1:0] dp_l2_q, dp_l2_d;
  logic [LOGL3-1:0] dp_l3_q, dp_l3_d;

  logic [LAT:0]     tag_v_q;
  logic [IDW-1:0]   tag_id_q [LAT+1];

  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Arbiter: first valid requester at or after ptr, only while a FIFO slot is reserved-free.
  always_comb begin
    logic found;
    int   idx;
    grant_s = '0;
    gid_s   = '0;
    csel_s  = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!found && bus.req_valid[idx] && (credits_q != '0) && !rst) begin
        found        = 1'b1;
        grant_s[idx] = 1'b1;
        gid_s        = IDW'(idx);
        csel_s       = bus.req_C[idx*K +: K];
      end else begin
        found = found;
      end
    end
  end

  assign hs_s   = |grant_s;
  assign push_s = tag_v_q[LAT];
  assign pop_s  = (cnt_q != '0) && bus.res_ready;

  // Next-state for pointer, credits, issue registers and FIFO occupancy.
  always_comb begin
    ptr_d     = ptr_q;
    credits_d = credits_q;
    cnt_d     = cnt_q;
    dp_c_d    = '0;
    dp_l1_d   = '0;
    dp_l2_d   = '0;
    dp_l3_d   = '0;
    if (hs_s) begin
      ptr_d   = (gid_s == IDW'(NREQ - 1)) ? '0 : gid_s + IDW'(1);
      dp_c_d  = csel_s;
      dp_l1_d = cfg_l1_q[gid_s];
      dp_l2_d = cfg_l2_q[gid_s];
      dp_l3_d = (USE_L3 != 0) ? cfg_l3_q[gid_s] : '0;
    end else begin
      ptr_d = ptr_q;
    end
    case ({hs_s, pop_s})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state, issue registers, tag line and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      credits_q <= CW'(FIFO_DEPTH);
      dp_c_q    <= '0;
      dp_l1_q   <= '0;
      dp_l2_q   <= '0;
      dp_l3_q   <= '0;
      tag_v_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      for (int i = 0; i <= LAT; i++) tag_id_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      credits_q   <= credits_d;
      dp_c_q      <= dp_c_d;
      dp_l1_q     <= dp_l1_d;
      dp_l2_q     <= dp_l2_d;
      dp_l3_q     <= dp_l3_d;
      tag_v_q     <= {tag_v_q[LAT-1:0], hs_s};
      tag_id_q[0] <= gid_s;
      for (int i = 1; i <= LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
      wr_q        <= push_s ? wr_q + AW'(1) : wr_q;
      rd_q        <= pop_s ? rd_q + AW'(1) : rd_q;
      cnt_q       <= cnt_d;
    end
  end

  // Per-requester shift configuration; an issue in the same cycle still reads the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        cfg_l1_q[i] <= '0;
        cfg_l2_q[i] <= '0;
        cfg_l3_q[i] <= '0;
      end
    end else if (bus.cfg_we && (int'(bus.cfg_id) < NREQ)) begin
      cfg_l1_q[bus.cfg_id] <= bus.cfg_L1;
      cfg_l2_q[bus.cfg_id] <= bus.cfg_L2;
      cfg_l3_q[bus.cfg_id] <= (USE_L3 != 0) ? bus.cfg_L3 : '0;
    end else begin
      cfg_l1_q <= cfg_l1_q;
    end
  end

  // Result storage; the credit rule guarantees a free slot whenever a tag arrives.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_q[wr_q] <= {bus.dp_T, tag_id_q[LAT]};
    end else begin
      mem_q <= mem_q;
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.dp_C      = dp_c_q;
  assign bus.dp_L1     = dp_l1_q;
  assign bus.dp_L2     = dp_l2_q;
  assign bus.dp_L3     = dp_l3_q;
  assign bus.res_valid = (cnt_q != '0);
  assign bus.res_T     = mem_q[rd_q][EW-1:IDW];
  assign bus.res_id    = mem_q[rd_q][IDW-1:0];
  assign bus.busy      = (|tag_v_q) || (cnt_q != '0);
endmodule

// File: tb/tb_montgomery_shift_sched.sv
// Directed bench for montgomery_shift_sched with a behavioural LAT-stage stand-in for the datapath.
module tb_montgomery_shift_sched;
  localparam int LOGQ = 32;
  localparam int K    = 2 * LOGQ;
  localparam int NREQ = 4;
  localparam int LAT  = 7;
  localparam int LOGT = 33;
  localparam int FD   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail   = 0;

  montgomery_shift_sched_if #(.LOGQ(LOGQ), .LOGL1(5), .LOGL2(5), .LOGL3(5),
                              .NREQ(NREQ), .LOGT(LOGT)) bus ();

  montgomery_shift_sched #(.LOGQ(LOGQ), .LOGL1(5), .LOGL2(5), .LOGL3(5), .USE_L3(1),
                           .NREQ(NREQ), .LAT(LAT), .FIFO_DEPTH(FD), .LOGT(LOGT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [LOGT-1:0] golden(input logic [K-1:0] c, input logic [4:0] l1,
                                             input logic [4:0] l2, input logic [4:0] l3);
    logic [LOGT-1:0] sh;
    sh = {18'd0, l1, l2, l3};
    return c[LOGT-1:0] ^ c[K-1 -: LOGT] ^ sh;
  endfunction

  logic [LOGT-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= golden(bus.dp_C, bus.dp_L1, bus.dp_L2, bus.dp_L3);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.dp_T = pipe[LAT-1];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.req_valid = '0;
    bus.req_C     = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_id    = '0;
    bus.cfg_L1    = '0;
    bus.cfg_L2    = '0;
    bus.cfg_L3    = '0;
    bus.res_ready = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready); end
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.dp_C !== 64'd0) begin n_fail++; $display("FAIL reset_dp_C got %h want 0", bus.dp_C); end
    n_checks++; if (bus.dp_L1 !== 5'd0) begin n_fail++; $display("FAIL reset_dp_L1 got %0d want 0", bus.dp_L1); end
  endtask

  task automatic test_single;
    logic [K-1:0] c;
    int cyc;
    c = 64'h0000_0001_2345_6789;
    do_reset();
    bus.cfg_we = 1'b1; bus.cfg_id = 2'd0; bus.cfg_L1 = 5'd3; bus.cfg_L2 = 5'd1; bus.cfg_L3 = 5'd2;
    tick();
    bus.cfg_we = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_C[0 +: K] = c;
    bus.res_ready = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    n_checks++; if (bus.dp_L1 !== 5'd3 || bus.dp_L2 !== 5'd1 || bus.dp_L3 !== 5'd2)
      begin n_fail++; $display("FAIL single_dp_L got %0d/%0d/%0d want 3/1/2", bus.dp_L1, bus.dp_L2, bus.dp_L3); end
    n_checks++; if (bus.dp_C !== c) begin n_fail++; $display("FAIL single_dp_C got %h want %h", bus.dp_C, c); end
    cyc = 0;
    while (bus.res_valid !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
    n_checks++; if (cyc !== LAT + 1) begin n_fail++; $display("FAIL single_latency got %0d want %0d", cyc, LAT + 1); end
    n_checks++; if (bus.res_id !== 2'd0) begin n_fail++; $display("FAIL single_res_id got %0d want 0", bus.res_id); end
    n_checks++; if (bus.res_T !== golden(c, 5'd3, 5'd1, 5'd2))
      begin n_fail++; $display("FAIL single_res_T got %h want %h", bus.res_T, golden(c, 5'd3, 5'd1, 5'd2)); end
    tick();
    n_checks++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL single_drain got valid=%b busy=%b want 0/0", bus.res_valid, bus.busy); end
  endtask

  task automatic test_round_robin;
    logic [K-1:0]    cs [NREQ];
    logic [LOGT-1:0] exp_t [$];
    int              exp_id [$];
    int              exp_rdy [$];
    logic [NREQ-1:0] er;
    int ptr, cred, grants, got, sn, pop;
    bit vis;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      cs[i] = 64'h1111_2222_3333_4444 * (i + 1) + 64'(i);
      bus.req_C[i*K +: K] = cs[i];
    end
    bus.res_ready = 1'b1;
    ptr = 0; cred = FD; grants = 0; got = 0;
    for (sn = 0; sn < 2000 && got < 100; sn++) begin
      bus.req_valid = (grants < 100) ? 4'b1111 : 4'b0000;
      #1;
      er = (cred != 0 && grants < 100) ? (4'b0001 << ptr) : 4'b0000;
      n_checks++; if (bus.req_ready !== er) begin n_fail++; $display("FAIL rr_grant sample %0d got %b want %b", sn, bus.req_ready, er); end
      vis = (exp_rdy.size() > 0) && (exp_rdy[0] <= sn);
      n_checks++; if (bus.res_valid !== vis) begin n_fail++; $display("FAIL rr_res_valid sample %0d got %b want %b", sn, bus.res_valid, vis); end
      pop = 0;
      if (vis) begin
        n_checks++; if (bus.res_id !== 2'(exp_id[0]) || bus.res_T !== exp_t[0])
          begin n_fail++; $display("FAIL rr_result #%0d got id=%0d T=%h want id=%0d T=%h", got, bus.res_id, bus.res_T, exp_id[0], exp_t[0]); end
        void'(exp_id.pop_front()); void'(exp_t.pop_front()); void'(exp_rdy.pop_front());
        got++;
        pop = 1;
      end
      if (er != 4'b0000) begin
        exp_id.push_back(ptr);
        exp_t.push_back(golden(cs[ptr], 5'd0, 5'd0, 5'd0));
        exp_rdy.push_back(sn + LAT + 2);
        ptr = (ptr + 1) % NREQ;
        grants++;
        cred = cred - 1;
      end
      cred = cred + pop;
      @(posedge clk);
      #0;
    end
    #1;
    bus.req_valid = 4'b0000;
    n_checks++; if (got !== 100) begin n_fail++; $display("FAIL rr_count got %0d want 100", got); end
  endtask

  task automatic test_backpressure;
    int grants;
    do_reset();
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b1111;
    grants = 0;
    for (int i = 0; i < 25; i++) begin
      #1;
      grants += $countones(bus.req_ready);
      tick();
    end
    n_checks++; if (grants !== FD) begin n_fail++; $display("FAIL bp_grants got %0d want %0d", grants, FD); end
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stalled got %b want 0000", bus.req_ready); end
    n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full_valid got %b want 1", bus.res_valid); end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_one_credit got %b want 0001", bus.req_ready); end
    tick();
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_credit_used got %b want 0000", bus.req_ready); end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_cfg_same_edge;
    do_reset();
    bus.res_ready = 1'b1;
    bus.cfg_we = 1'b1; bus.cfg_id = 2'd1; bus.cfg_L1 = 5'd3; bus.cfg_L2 = 5'd0; bus.cfg_L3 = 5'd0;
    tick();
    bus.cfg_L1 = 5'd7;
    bus.req_valid = 4'b0010;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL cfg_grant got %b want 0010", bus.req_ready); end
    tick();
    bus.cfg_we = 1'b0;
    n_checks++; if (bus.dp_L1 !== 5'd3) begin n_fail++; $display("FAIL cfg_old_value got %0d want 3", bus.dp_L1); end
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL cfg_regrant got %b want 0010", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    n_checks++; if (bus.dp_L1 !== 5'd7) begin n_fail++; $display("FAIL cfg_new_value got %0d want 7", bus.dp_L1); end
    for (int i = 0; i < 15; i++) tick();
  endtask

  task automatic test_reset_midop;
    int grants;
    do_reset();
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 7; i++) tick();
    bus.req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (bus.res_valid !== 1'b1 || bus.busy !== 1'b1)
      begin n_fail++; $display("FAIL mid_pre got valid=%b busy=%b want 1/1", bus.res_valid, bus.busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      n_checks++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0)
        begin n_fail++; $display("FAIL mid_discard cycle %0d got valid=%b busy=%b want 0/0", i, bus.res_valid, bus.busy); end
      tick();
    end
    bus.req_valid = 4'b1111;
    grants = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      grants += $countones(bus.req_ready);
      tick();
    end
    bus.req_valid = 4'b0000;
    n_checks++; if (grants !== FD) begin n_fail++; $display("FAIL mid_credits got %0d want %0d", grants, FD); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_cfg_same_edge();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/montgomery_shift_sched.md
Name: montgomery_shift_sched

Overview:
Shares one fixed-latency montgomery_shift pipeline between NREQ requesters. The block provides:
- round-robin arbitration of requests;
- per-requester modulus configuration (L1/L2/L3 shift amounts);
- a tag delay line matching the datapath latency;
- a credit-protected result FIFO, so that output back-pressure never requires stalling the non-stallable datapath.

It sits between client engines (e.g. NTT butterflies) and a montgomery_shift instance.

Parameters:
LOGQ, 32, modulus width; K = 2*LOGQ is the operand width.
LOGQH, 15, width of qH in the datapath.
LOGL1 / LOGL2 / LOGL3, 5 / 5 / 5, shift-amount widths.
USE_L3, 1, when 0 dp_L3 is driven 0 and cfg_L3 is ignored.
NREQ, 4, number of requesters (>=2).
LAT, 7, datapath latency in cycles; must equal montgomery_shift LAT for the chosen FF_* settings.
FIFO_DEPTH, 8, result FIFO entries (power of 2, >=2).
IDW, $clog2(NREQ), derived width of a requester id.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-high reset.
req_valid  in  NREQ  per-requester request valid.
req_ready  out  NREQ  one-hot grant; a handshake is req_valid[i] & req_ready[i].
req_C  in  NREQ*K  operands; slice i is requester i.
cfg_we  in  1  write strobe for a configuration entry.
cfg_id  in  IDW  configuration entry selected for write.
cfg_L1 / cfg_L2 / cfg_L3  in  LOGL1 / LOGL2 / LOGL3  shift amounts to write.
dp_C  out  K  datapath operand (registered).
dp_L1 / dp_L2 / dp_L3  out  LOGL1 / LOGL2 / LOGL3  datapath shifts (registered).
dp_T  in  LOGT  datapath result; LOGT = montgomery_shift LOGT.
res_valid  out  1  result available.
res_ready  in  1  consumer accepts the result.
res_T  out  LOGT  result.
res_id  out  IDW  requester id of the result.
busy  out  1  work is in flight or the FIFO is non-empty.

Behaviour:
- Reset values:
  - req_ready, res_valid and busy = 0; dp_C and dp_L* = 0; all cfg registers = 0.
  - Round-robin pointer = 0; tag-line valid bits cleared; FIFO emptied; credits = FIFO_DEPTH.
- Reset mid-operation discards all in-flight and queued results. Datapath output for discarded work is never pushed.
- Arbiter:
  - Combinational: req_ready is the first i with req_valid[i] set, searching from ptr upward (mod NREQ), and only when credits != 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
  - After a grant to i, ptr = (i+1) mod NREQ. With no grant, ptr holds.
  - At most one handshake per cycle.
- Issue:
  - On a handshake at edge e, the registers capture dp_C = req_C[i] and dp_L* = cfg[i]; tag line stage 0 = {1, i}.
  - With no handshake, dp_C = 0, dp_L* = 0 and tag valid = 0.
- Tag line:
  - LAT+1 register stages.
  - At edge e+LAT+1, if the tag is valid, {dp_T, id} is pushed to the FIFO.
  - Pushes never overflow, because of the credit rule.
- Credits:
  - Decrement on a handshake; increment on a pop (res_valid & res_ready); both in the same cycle leaves credits unchanged.
  - Credits never exceed FIFO_DEPTH and never go below 0.
- FIFO:
  - Show-ahead: res_T, res_id and res_valid are driven from the head entry.
  - Push and pop in the same cycle is allowed, including when the FIFO is full and when it is empty: an empty-FIFO push is visible the following cycle.
  - Results leave in issue order.
- Minimum latency: a handshake at edge e gives res_valid high after edge e+LAT+1, when the FIFO is empty.
- Config:
  - cfg_we writes entry cfg_id at the edge.
  - An issue at the same edge to the same id uses the old value; the new value applies from the next issue.
- busy = (any tag-line valid) | FIFO non-empty.

Test Plan:
1. Reset, all inputs idle, held 10 cycles -> req_ready=0, res_valid=0, busy=0, dp_C=0.
2. cfg id0 with L1=3, L2=1, L3=2 (qH=0x400A); req0 with C=0x0000_0001_2345_6789 -> dp_L1=3, dp_L2=1, dp_L3=2 one cycle after the handshake; res_valid exactly LAT+1=8 cycles after the handshake; res_id=0; res_T equals the golden model value.
3. All 4 requesters valid continuously, res_ready=1 -> grants 0,1,2,3,0,1,... one per cycle; results in the same id order at one per cycle; no loss over 100 requests.
4. res_ready=0, all requesters valid -> exactly 8 handshakes, then req_ready=0. Pulse res_ready for 1 cycle -> exactly one further grant the next cycle.
5. cfg_we to id1 (L1=7) at the same edge as a grant to id1 with old L1=3 -> that issue shows dp_L1=3; the next id1 issue shows dp_L1=7.
6. rst pulsed with 5 requests in flight and 2 queued -> res_valid=0 the next cycle and for the following LAT+2 cycles; credits back to 8 (8 grants accepted with res_ready=0).
